// File: rtl/spw_pkg.sv
// Shared constants for the packet CRC FIFO: CRC-32 polynomial and seed.
package spw_pkg;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
endpackage

// File: rtl/crc32_dw_step.sv
// One-cycle CRC-32 update over a DW-bit word, MSB first, unreflected.
module crc32_dw_step
  import spw_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [31:0]   crc_in,
  input  logic [DW-1:0] data,
  output logic [31:0]   crc_nxt
);

  // Unrolled bit-serial LFSR; synthesis flattens this to an XOR network.
  always_comb begin
    crc_nxt = crc_in;
    for (int i = DW - 1; i >= 0; i--) begin
      if (crc_nxt[31] ^ data[i]) begin
        crc_nxt = {crc_nxt[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_nxt = {crc_nxt[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/pkt_crc_fifo.sv
// Synchronous FIFO storing {eop, data} words, with a running CRC-32 that
// publishes the checksum of each packet as its EOP word is written.
module pkt_crc_fifo
  import spw_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 2**AW - 2,
  parameter int CRC_EN   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          wr_eop,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_eop,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          wr_ovf,
  output logic          rd_unf,
  output logic [31:0]   crc_out,
  output logic          crc_valid
);

  localparam int DEPTH = 2**AW;

  logic [DW:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, af_q;
  logic          ovf_q, unf_q;
  logic [DW-1:0] dout_q;
  logic          dout_eop_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses only registered flags, so a read never frees room for a
  // same-cycle write and a write never falls through to a same-cycle read.
  assign wr_acc = wr_en & ~full_q & ~rst;
  assign rd_acc = rd_en & ~empty_q & ~rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
    count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dout_q     <= '0;
      dout_eop_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      af_q     <= (count_d >= (AW+1)'(AF_LEVEL));
      ovf_q    <= wr_en & full_q;
      unf_q    <= rd_en & empty_q;
      if (rd_acc) begin
        {dout_eop_q, dout_q} <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {wr_eop, din};
    end
  end

  assign dout        = dout_q;
  assign dout_eop    = dout_eop_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign wr_ovf      = ovf_q;
  assign rd_unf      = unf_q;

  if (CRC_EN != 0) begin : g_crc
    logic [31:0] crc_run_q, crc_step, crc_out_q;
    logic        crc_valid_q;

    crc32_dw_step #(.DW(DW)) u_step (
      .crc_in  (crc_run_q),
      .data    (din),
      .crc_nxt (crc_step)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        crc_run_q   <= CRC_INIT;
        crc_out_q   <= '0;
        crc_valid_q <= 1'b0;
      end else begin
        crc_valid_q <= wr_acc & wr_eop;
        if (wr_acc) begin
          if (wr_eop) begin
            crc_out_q <= crc_step;
            crc_run_q <= CRC_INIT;
          end else begin
            crc_run_q <= crc_step;
          end
        end
      end
    end

    assign crc_out   = crc_out_q;
    assign crc_valid = crc_valid_q;
  end else begin : g_no_crc
    assign crc_out   = '0;
    assign crc_valid = 1'b0;
  end

endmodule

// File: tb/tb_pkt_crc_fifo.sv
// Scoreboard bench: three FIFO instances (DW=8/16/32) share one stimulus
// stream; a queue-based model per instance predicts reads, flags and CRCs.
module tb_pkt_crc_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, wr_eop;
  logic [31:0] din;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s actual=event required=no-event", name);
  endtask

  // Reference CRC: the textbook MSB-first polynomial division, one bit at a time.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d, input int w);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = w - 1; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = 8 << gi;

    logic [W-1:0] dout;
    logic         dout_eop, full, empty, af, ovf, unf, cv;
    logic [4:0]   count;
    logic [31:0]  crc_out;

    pkt_crc_fifo #(.DW(W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .din         (din[W-1:0]),
      .wr_eop      (wr_eop),
      .rd_en       (rd_en),
      .dout        (dout),
      .dout_eop    (dout_eop),
      .full        (full),
      .empty       (empty),
      .almost_full (af),
      .count       (count),
      .wr_ovf      (ovf),
      .rd_unf      (unf),
      .crc_out     (crc_out),
      .crc_valid   (cv)
    );

    logic [32:0] mq[$];
    logic [32:0] rdq[$];
    logic [31:0] crcq[$];
    logic [31:0] mcrc = 32'hFFFFFFFF;
    int          mcount = 0;
    bit          e_ovf = 0, e_unf = 0, e_cv = 0;
    bit          rd_seen = 0, rst_seen = 0;
    logic [32:0] hold_d = '0;
    logic [31:0] hold_crc = '0;
    int          cv_pulses = 0;
    int          pend = 0;

    // Model: FIFO as a queue, decisions from the model's own occupancy.
    always @(posedge clk) begin
      rst_seen = rst;
      rd_seen  = !rst && rd_en && !empty;
      if (rst) begin
        mq.delete(); rdq.delete(); crcq.delete();
        mcount = 0; mcrc = 32'hFFFFFFFF;
        e_ovf = 0; e_unf = 0; e_cv = 0;
      end else begin
        e_ovf = wr_en && (mcount == 16);
        e_unf = rd_en && (mcount == 0);
        e_cv  = 0;
        if (rd_en && mcount > 0) begin
          rdq.push_back(mq.pop_front());
          mcount--;
        end
        if (wr_en && !e_ovf) begin
          mq.push_back({wr_eop, 32'(din[W-1:0])});
          mcount++;
          mcrc = crc_ref(mcrc, 32'(din[W-1:0]), W);
          if (wr_eop) begin
            crcq.push_back(mcrc);
            mcrc = 32'hFFFFFFFF;
            e_cv = 1;
          end
        end
      end
    end

    // Monitor: pops expected data when the DUT takes a read or pulses crc_valid.
    always @(negedge clk) begin
      if (rst_seen) begin
        hold_d   = '0;
        hold_crc = '0;
      end
      if (rd_seen) begin
        if (rdq.size() == 0) fail_now($sformatf("dw%0d_unexpected_read", W));
        else hold_d = rdq.pop_front();
      end
      if (cv) begin
        cv_pulses++;
        if (crcq.size() == 0) fail_now($sformatf("dw%0d_unexpected_crc_valid", W));
        else hold_crc = crcq.pop_front();
      end
      check($sformatf("dw%0d_dout", W), {31'd0, dout_eop, 32'(dout)}, {31'd0, hold_d});
      check($sformatf("dw%0d_crc_valid", W), cv, e_cv);
      check($sformatf("dw%0d_crc_out", W), crc_out, hold_crc);
      check($sformatf("dw%0d_count", W), count, mcount);
      check($sformatf("dw%0d_full", W), full, mcount == 16);
      check($sformatf("dw%0d_empty", W), empty, mcount == 0);
      check($sformatf("dw%0d_almost_full", W), af, mcount >= 14);
      check($sformatf("dw%0d_wr_ovf", W), ovf, e_ovf);
      check($sformatf("dw%0d_rd_unf", W), unf, e_unf);
      pend = rdq.size() + crcq.size();
    end
  end

  task automatic drive(input bit w, input bit r, input bit e, input logic [31:0] d);
    wr_en  = w;
    rd_en  = r;
    wr_eop = e;
    din    = d;
    @(negedge clk);
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_eop = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check("rst_empty", g_dut[0].empty, 1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) drive(1, 0, i == 8, 32'h31 + i);
    drive(0, 0, 0, 0);
    check("crc_123456789", g_dut[0].crc_out, 32'h0376E6E7);
    check("crc_pulses_1", g_dut[0].cv_pulses, 1);
    repeat (9) drive(0, 1, 0, 0);

    for (int i = 0; i < 17; i++) drive(1, 0, 0, $urandom);
    check("full_after_17", g_dut[0].full, 1);
    check("count_after_17", g_dut[0].count, 16);
    repeat (16) drive(0, 1, 0, 0);
    check("empty_after_16_reads", g_dut[0].empty, 1);
    drive(0, 1, 0, 0);
    check("count_after_unf", g_dut[0].count, 0);

    repeat (16) drive(1, 0, 0, $urandom);
    drive(1, 1, 0, $urandom);
    check("count_wr_rd_at_full", g_dut[0].count, 15);
    repeat (15) drive(0, 1, 0, 0);
    drive(1, 1, 0, $urandom);
    check("count_wr_rd_at_empty", g_dut[0].count, 1);
    drive(0, 1, 0, 0);

    for (int i = 0; i < 5; i++) drive(1, 0, 0, 32'h41 + i);
    rst = 1'b1;
    drive(1, 1, 1, 32'hAA);
    drive(1, 1, 0, 32'h55);
    check("rst_crc_out", g_dut[0].crc_out, 0);
    check("rst_count", g_dut[0].count, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) drive(1, 0, i == 8, 32'h31 + i);
    drive(0, 0, 0, 0);
    check("crc_after_rst", g_dut[0].crc_out, 32'h0376E6E7);
    check("crc_pulses_2", g_dut[0].cv_pulses, 2);
    repeat (9) drive(0, 1, 0, 0);

    for (int c = 0; c < 1000; c++) begin
      case (c / 250)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 10; end
      endcase
      drive($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom_range(3) == 0, $urandom);
    end
    repeat (20) drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    check("dw8_pending", g_dut[0].pend, 0);
    check("dw16_pending", g_dut[1].pend, 0);
    check("dw32_pending", g_dut[2].pend, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
